// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage for the 5-stage RV32I pipeline: owns the PC, keeps a single
// memory request in flight and feeds {pc, instr, pc+4} to IF/ID, inserting NOPs when idle.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc_next_out,
   output logic        fetch_valid
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [31:0] pc;
   logic [31:0] buf_instr;
   logic [1:0]  state;
   logic        buf_valid;
   logic        started;
   logic        resp_hit;
   logic        consume;
   logic [31:0] redirect_target;

   assign resp_hit        = (state == WAIT) && imem_rvalid;
   assign consume         = fetch_valid && !stall && !redirect;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      imem_req    = started && (state == IDLE) && !buf_valid && !redirect;
      imem_addr   = pc;
      pc_out      = pc;
      pc_next_out = pc + 32'd4;
      instr_out   = NOP_INSTR;
      fetch_valid = 1'b0;
      if (started) begin
         // A held (stalled) instruction wins over the same-cycle memory bypass.
         if (buf_valid) begin
            instr_out   = buf_instr;
            fetch_valid = !redirect;
         end else if (resp_hit) begin
            instr_out   = imem_rdata;
            fetch_valid = !redirect;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_PC;
         state     <= IDLE;
         buf_valid <= 1'b0;
         buf_instr <= 32'h0000_0000;
         started   <= 1'b0;
      end else if (!started) begin
         started <= 1'b1;
      end else if (redirect) begin
         pc        <= redirect_target;
         buf_valid <= 1'b0;
         // An in-flight response must still be swallowed before a new request goes out.
         if (((state == WAIT) || (state == DROP)) && !imem_rvalid) begin
            state <= DROP;
         end else begin
            state <= IDLE;
         end
      end else begin
         if (consume) begin
            pc        <= pc + 32'd4;
            buf_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (imem_req && imem_ready) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state <= IDLE;
                  if (!consume) begin
                     buf_valid <= 1'b1;
                     buf_instr <= imem_rdata;
                  end
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a behavioural memory/fetch model drives a
// scoreboard of expected {pc, instr} pairs, plus directed checks for the corner cases.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic [31:0] pc_next_out;
   logic        fetch_valid;

   if_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .instr_out   (instr_out),
      .pc_next_out (pc_next_out),
      .fetch_valid (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the fetch stage and the memory behind it.
   logic        started_m;
   logic        pend;
   logic        drop;
   logic        exp_buf;
   logic        got;
   logic        exp_fv;
   logic        exp_req;
   logic        late_rv;
   logic        ovr_en;
   logic [31:0] ovr;
   logic [31:0] exp_pc;
   logic [31:0] pend_addr;
   int          pend_cnt;
   int          pend_lat;
   int          next_lat;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got_v, exp_v, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : {a[19:0], 12'h093};
   endfunction

   // Drive the memory response for this cycle, then sample and compare everything.
   task automatic pre();
      got         = pend && (pend_cnt >= pend_lat);
      imem_rvalid = got || late_rv;
      imem_rdata  = ovr_en ? ovr : mem_word(pend_addr);
      exp_fv      = !redirect && (exp_buf || (got && !drop));
      exp_req     = started_m && !pend && !exp_buf && !redirect;
      if (got && !drop && !redirect) exp_q.push_back({pend_addr, imem_rdata});
      #1;
      check("req", imem_req, exp_req);
      if (exp_req) check("addr", imem_addr, exp_pc);
      check("fetch_valid", fetch_valid, exp_fv);
      check("pc_out", pc_out, exp_pc);
      check("pc_next_out", pc_next_out, exp_pc + 32'd4);
      if (exp_fv && exp_q.size() != 0) begin
         check("sb_instr", instr_out, exp_q[0][31:0]);
         check("sb_pc", pc_out, exp_q[0][63:32]);
      end else if (!exp_fv && !redirect) begin
         check("bubble", instr_out, NOP_INSTR);
      end
   endtask

   // Advance one clock and update the model with what the edge should have done.
   task automatic post();
      logic        cons;
      logic        acc;
      logic [31:0] old_pc;
      cons   = exp_fv && !stall && !redirect;
      acc    = exp_req && imem_ready;
      old_pc = exp_pc;
      @(posedge clk);
      if (redirect) begin
         exp_pc  = redirect_pc & 32'hFFFF_FFFC;
         exp_buf = 1'b0;
         exp_q.delete();
         if (pend && !got) drop = 1'b1;
      end else if (cons) begin
         exp_pc  = exp_pc + 32'd4;
         exp_buf = 1'b0;
         void'(exp_q.pop_front());
      end else if (got && !drop) begin
         exp_buf = 1'b1;
      end
      if (got) begin
         pend = 1'b0;
         drop = 1'b0;
      end else if (pend) begin
         pend_cnt++;
      end
      if (acc) begin
         pend      = 1'b1;
         drop      = 1'b0;
         pend_addr = old_pc;
         pend_cnt  = 1;
         pend_lat  = next_lat;
      end
      started_m = 1'b1;
      @(negedge clk);
   endtask

   task automatic cyc();
      pre();
      post();
   endtask

   // Assert reset at a falling edge, check the idle outputs immediately, release later.
   task automatic do_reset();
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      late_rv     = 1'b0;
      imem_rvalid = 1'b0;
      #1;
      check("rst_req", imem_req, 1'b0);
      check("rst_fetch_valid", fetch_valid, 1'b0);
      check("rst_instr", instr_out, NOP_INSTR);
      check("rst_pc_out", pc_out, RESET_PC);
      check("rst_pc_next", pc_next_out, RESET_PC + 32'd4);
      started_m = 1'b0;
      pend      = 1'b0;
      drop      = 1'b0;
      exp_buf   = 1'b0;
      exp_pc    = RESET_PC;
      pend_addr = 32'h0;
      pend_cnt  = 0;
      pend_lat  = 1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      late_rv     = 1'b0;
      ovr_en      = 1'b0;
      ovr         = 32'h0;
      next_lat    = 1;
      @(negedge clk);
      do_reset();

      // First fetch after reset: no request until started, then addr 0, data next cycle.
      pre(); check("t1_no_req_before_start", imem_req, 1'b0); post();
      pre(); check("t1_req", imem_req, 1'b1); check("t1_addr", imem_addr, 32'h0); post();
      pre();
      check("t1_valid", fetch_valid, 1'b1);
      check("t1_instr", instr_out, 32'h0050_0093);
      check("t1_pc_next", pc_next_out, 32'h4);
      post();
      pre(); check("t1_next_addr", imem_addr, 32'h4); post();

      // Response lands under a 3-cycle stall: buffered and held, then consumed once.
      stall = 1'b1;
      cyc();
      repeat (2) begin
         pre();
         check("t2_hold_no_req", imem_req, 1'b0);
         check("t2_hold_pc", pc_out, 32'h4);
         check("t2_hold_instr", instr_out, mem_word(32'h4));
         post();
      end
      stall = 1'b0;
      pre(); check("t2_release_valid", fetch_valid, 1'b1); post();
      next_lat = 3;
      pre(); check("t2_next_addr", imem_addr, 32'h8); post();

      // Redirect while waiting: the late response is dropped and never presented.
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      pre(); check("t3_redirect_bubble", fetch_valid, 1'b0); post();
      redirect = 1'b0;
      next_lat = 1;
      pre(); check("t3_drop_no_req", imem_req, 1'b0); post();
      ovr_en = 1'b1;
      ovr    = 32'hDEAD_BEEF;
      pre(); check("t3_dead_not_valid", fetch_valid, 1'b0); post();
      ovr_en = 1'b0;
      pre(); check("t3_restart_addr", imem_addr, 32'h0000_0100); post();

      // Redirect coincides with the response; unaligned target is truncated.
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0203;
      pre(); check("t4_discard", fetch_valid, 1'b0); post();
      redirect   = 1'b0;
      imem_ready = 1'b0;

      // Memory not ready for 4 cycles: request and address hold steady.
      repeat (4) begin
         pre();
         check("t5_req_held", imem_req, 1'b1);
         check("t5_addr_held", imem_addr, 32'h0000_0200);
         check("t5_nop", instr_out, NOP_INSTR);
         post();
      end
      imem_ready = 1'b1;
      cyc();
      pre(); check("t5_valid", fetch_valid, 1'b1); post();

      // Redirect to the top of the address space and wrap past it.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      pre(); check("t6_req_masked", imem_req, 1'b0); post();
      redirect = 1'b0;
      pre(); check("t6_addr_top", imem_addr, 32'hFFFF_FFFC); post();
      pre();
      check("t6_pc_top", pc_out, 32'hFFFF_FFFC);
      check("t6_pc_next_wrap", pc_next_out, 32'h0);
      post();
      pre(); check("t6_wrap_addr", imem_addr, 32'h0); post();

      // Reset pulse with a transaction in flight; a stray late rvalid must be ignored.
      do_reset();
      late_rv = 1'b1;
      pre(); check("t7_no_req_before_start", imem_req, 1'b0); post();
      pre(); check("t7_late_ignored", fetch_valid, 1'b0); check("t7_addr", imem_addr, RESET_PC); post();
      late_rv = 1'b0;

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         stall       = ($urandom_range(0, 2) == 0);
         imem_ready  = ($urandom_range(0, 3) != 0);
         next_lat    = $urandom_range(1, 3);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = $urandom;
         cyc();
      end
      stall    = 1'b0;
      redirect = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
